mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, wait states inserted per access (0..15); used only when MEMRSP_WAIT_EN is defined.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  1  access request from the CPU memory initiator, level-sampled in IDLE.
REQ-005 iwr  input  1  1 = write, 0 = read; sampled with req.
REQ-006 addr  input  6  word address (64 x 8 storage); sampled with req.
REQ-007 din  input  8  write data; sampled with req.
REQ-008 dout  output  8  read data, registered.
REQ-009 to_MAR  output  8  copy of dout, used for indirect address load.
REQ-010 ack  output  1  one-cycle response pulse.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 ld_we  input  1  host program-load write strobe.
REQ-013 ld_addr  input  6  host load address.
REQ-014 ld_data  input  8  host load data.
REQ-015 ld_ack  output  1  one-cycle pulse confirming the host write was committed.

Function
REQ-016 Storage SHALL be 64 x 8; addr covers the full range, so there is no out-of-range case.
REQ-017 FSM states SHALL be IDLE, WAIT, RESP; ack = (state == RESP); busy = (state != IDLE).
REQ-018 In IDLE with req=1 at edge E0: latch iwr/addr/din; go to RESP (no waits) or WAIT with counter = WAIT_CYCLES.
REQ-019 In WAIT: counter decrements each edge; at the edge where counter == 1, go to RESP; ack therefore rises at edge E0+WAIT_CYCLES.
REQ-020 On the edge entering RESP: for a read, dout/to_MAR <= mem[latched addr]; for a write, mem[latched addr] <= latched din and dout is unchanged.
REQ-021 RESP SHALL always return to IDLE on the next edge; ack is high for exactly one cycle.
REQ-022 The initiator drops req during the ack cycle; req still high in IDLE after RESP SHALL be treated as a new transaction.
REQ-023 req changes while busy SHALL be ignored, because the latched request is used.
REQ-024 dout SHALL hold the last read value until the next read response.
REQ-025 ld_we SHALL be accepted only in IDLE with req=0: mem[ld_addr] <= ld_data at that edge, and ld_ack pulses high the following cycle.
REQ-026 When req=1 and ld_we=1 in the same IDLE cycle, req wins; the load is dropped with no ld_ack, and the host retries.
REQ-027 ld_we while busy SHALL be ignored with no ld_ack.
REQ-028 A read following a write to the same address SHALL return the newly written data.

Reset
REQ-029 rst=1 SHALL force, asynchronously: state=IDLE, dout=0, to_MAR=0, ack=0, busy=0, ld_ack=0, wait counter=0.
REQ-030 Reset during WAIT SHALL abort the access; a pending write is discarded and memory is left unmodified.
REQ-031 Memory contents SHALL NOT be cleared by reset, so a loaded program survives a CPU reset.

Configuration
REQ-032 Macro MEMRSP_WAIT_EN: when defined, WAIT state and counter are built and latency follows WAIT_CYCLES; WAIT_CYCLES=0 behaves as the undefined case.
REQ-033 When MEMRSP_WAIT_EN is undefined, WAIT and the counter SHALL be absent; every access goes IDLE->RESP and ack rises at E0 (1-cycle latency).

Verification
REQ-034 Macro off; load 0x3C at addr 5 via ld_we -> ld_ack pulses next cycle; read addr 5 -> ack in cycle after E0, dout=to_MAR=0x3C.
REQ-035 Macro on, WAIT_CYCLES=2; write 0xA5 to addr 63 -> busy high for 3 cycles, ack at E0+2; read addr 63 -> dout=0xA5.
REQ-036 req=1 (read addr 0) and ld_we=1 (addr 0, 0x77) in the same IDLE cycle -> read served, no ld_ack, mem[0] unchanged.
REQ-037 Macro on; assert rst mid-WAIT of a write of 0xFF to addr 9 -> outputs 0 immediately; a later read of addr 9 returns the previous value.
REQ-038 req held high for 4 cycles, macro off -> two transactions; ack pulses at E0 and E0+2; dout keeps its last read value during write responses.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: 64 x 8 memory answering a CPU memory initiator with a
// one-cycle ack pulse. A host port preloads the memory (program load) while
// the responder is idle.
//
// Build option: define MEMRSP_WAIT_EN to add a WAIT state with a wait-state
// counter loaded from WAIT_CYCLES. Without it every access goes IDLE -> RESP.
//
// Parameters
//   WAIT_CYCLES : wait states per access (0..15), used only with MEMRSP_WAIT_EN
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   req, iwr          : access request (level) and write flag
//   addr, din         : word address and write data, sampled with req
//   dout, to_MAR      : registered read data and its copy for MAR loading
//   ack, busy         : response pulse, FSM-not-idle flag
//   ld_we, ld_addr,
//   ld_data, ld_ack   : host load strobe, address, data, commit pulse
module mem_responder #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       iwr,
  input  logic [5:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [7:0] to_MAR,
  output logic       ack,
  output logic       busy,
  input  logic       ld_we,
  input  logic [5:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic       ld_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef MEMRSP_WAIT_EN
    WAIT = 2'd1,
`endif
    RESP = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [7:0] mem [64];

  // Access committed on this edge (the edge that enters RESP)
  logic       acc_go;
  logic       acc_wr;
  logic [5:0] acc_addr;
  logic [7:0] acc_din;
  logic       ld_go;

`ifdef MEMRSP_WAIT_EN
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 15) ? 4'd15 : 4'(WAIT_CYCLES);

  logic [3:0] cnt;
  logic       lat_wr;
  logic [5:0] lat_addr;
  logic [7:0] lat_din;

  // Live inputs are used when IDLE goes straight to RESP; after waiting,
  // the request latched at E0 is used so req changes while busy are ignored.
  always_comb begin
    acc_wr   = (state == IDLE) ? iwr  : lat_wr;
    acc_addr = (state == IDLE) ? addr : lat_addr;
    acc_din  = (state == IDLE) ? din  : lat_din;
  end
`else
  // WAIT_CYCLES has no effect in this build.
  if (WAIT_CYCLES > 15) begin : g_wait_cycles_unused
  end

  always_comb begin
    acc_wr   = iwr;
    acc_addr = addr;
    acc_din  = din;
  end
`endif

  always_comb begin
    state_nx = state;
    acc_go   = 1'b0;
    ld_go    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
`ifdef MEMRSP_WAIT_EN
          if (WAIT_INIT == 4'd0) begin
            state_nx = RESP;
            acc_go   = 1'b1;
          end else begin
            state_nx = WAIT;
          end
`else
          state_nx = RESP;
          acc_go   = 1'b1;
`endif
        end else if (ld_we) begin
          // A simultaneous req wins; the host load is only taken here.
          ld_go = 1'b1;
        end
      end
`ifdef MEMRSP_WAIT_EN
      WAIT: begin
        if (cnt == 4'd1) begin
          state_nx = RESP;
          acc_go   = 1'b1;
        end
      end
`endif
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      dout   <= '0;
      to_MAR <= '0;
      ld_ack <= 1'b0;
`ifdef MEMRSP_WAIT_EN
      cnt      <= '0;
      lat_wr   <= 1'b0;
      lat_addr <= '0;
      lat_din  <= '0;
`endif
    end else begin
      state  <= state_nx;
      ld_ack <= ld_go;
      if (acc_go && !acc_wr) begin
        dout   <= mem[acc_addr];
        to_MAR <= mem[acc_addr];
      end
`ifdef MEMRSP_WAIT_EN
      if (state == IDLE && req) begin
        lat_wr   <= iwr;
        lat_addr <= addr;
        lat_din  <= din;
        cnt      <= WAIT_INIT;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
`endif
    end
  end

  // Not reset: a loaded program survives a CPU reset. A write still waiting
  // when reset hits never reaches acc_go, so it is discarded.
  always_ff @(posedge clk) begin
    if (acc_go && acc_wr) begin
      mem[acc_addr] <= acc_din;
    end else if (ld_go) begin
      mem[ld_addr] <= ld_data;
    end
  end

  assign ack  = (state == RESP);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes the hand-computed
// dout expected at each ack; a monitor pops and compares on every ack.
module tb_mem_responder;

`ifdef MEMRSP_WAIT_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic       iwr = 1'b0;
  logic [5:0] addr = '0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic [7:0] to_MAR;
  logic       ack;
  logic       busy;
  logic       ld_we = 1'b0;
  logic [5:0] ld_addr = '0;
  logic [7:0] ld_data = '0;
  logic       ld_ack;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  mem_responder #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .iwr(iwr), .addr(addr), .din(din),
    .dout(dout), .to_MAR(to_MAR), .ack(ack), .busy(busy),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every ack must match the oldest expected response.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("dout", int'(dout), int'(e));
        chk("to_MAR", int'(to_MAR), int'(e));
      end
    end
  end

  task automatic host_load(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_we = 1'b0;
    chk("ld_ack_pulse", int'(ld_ack), 1);
    @(posedge clk); #1;
    chk("ld_ack_drop", int'(ld_ack), 0);
  endtask

  // One access; exp_dout is the dout expected while ack is high.
  task automatic do_access(input logic wr, input logic [5:0] a, input logic [7:0] d,
                           input logic [7:0] exp_dout);
    int n, bn;
    @(negedge clk);
    req = 1'b1; iwr = wr; addr = a; din = d;
    exp_q.push_back(exp_dout);
    @(posedge clk); #1;
    req = 1'b0;
    n = 0; bn = 0;
    while (n < 20) begin
      if (busy) bn++;
      if (ack) break;
      @(posedge clk); #1;
      n++;
    end
    chk("ack_latency", n, EXP_LAT);
    chk("busy_cycles", bn, EXP_LAT + 1);
    @(posedge clk); #1;
    chk("ack_one_cycle", int'(ack), 0);
    chk("busy_idle", int'(busy), 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_dout", int'(dout), 0);
    chk("rst_to_MAR", int'(to_MAR), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ld_ack", int'(ld_ack), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Host load then read back
    host_load(6'd5, 8'h3C);
    do_access(1'b0, 6'd5, 8'h00, 8'h3C);

    // req and ld_we together in IDLE: read wins, load dropped
    host_load(6'd0, 8'h11);
    @(negedge clk);
    req = 1'b1; iwr = 1'b0; addr = 6'd0;
    ld_we = 1'b1; ld_addr = 6'd0; ld_data = 8'h77;
    exp_q.push_back(8'h11);
    @(posedge clk); #1;
    req = 1'b0; ld_we = 1'b0;
    chk("conflict_no_ld_ack", int'(ld_ack), 0);
    wait_idle();
    do_access(1'b0, 6'd0, 8'h00, 8'h11);

    // Write, dout holds last read; read-after-write
    do_access(1'b1, 6'd20, 8'h5A, 8'h11);
    do_access(1'b0, 6'd20, 8'h00, 8'h5A);

    // ld_we while busy is ignored
    @(negedge clk);
    req = 1'b1; iwr = 1'b0; addr = 6'd5;
    exp_q.push_back(8'h3C);
    @(posedge clk); #1;
    req = 1'b0; ld_we = 1'b1; ld_addr = 6'd5; ld_data = 8'hEE;
    @(posedge clk); #1;
    ld_we = 1'b0;
    chk("busy_no_ld_ack", int'(ld_ack), 0);
    wait_idle();
    do_access(1'b0, 6'd5, 8'h00, 8'h3C);

`ifndef MEMRSP_WAIT_EN
    // req held for 4 edges: read 20 then write 21, two acks
    @(negedge clk);
    req = 1'b1; iwr = 1'b0; addr = 6'd20;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h5A);
    @(posedge clk); #1;
    chk("held_ack_e0", int'(ack), 1);
    iwr = 1'b1; addr = 6'd21; din = 8'hC3;
    @(posedge clk); #1;
    chk("held_ack_e1", int'(ack), 0);
    @(posedge clk); #1;
    chk("held_ack_e2", int'(ack), 1);
    @(posedge clk); #1;
    chk("held_ack_e3", int'(ack), 0);
    req = 1'b0; iwr = 1'b0;
    do_access(1'b0, 6'd21, 8'h00, 8'hC3);
`else
    // Wait-state write to the top address, then read back
    do_access(1'b1, 6'd63, 8'hA5, 8'h3C);
    do_access(1'b0, 6'd63, 8'h00, 8'hA5);

    // Reset mid-WAIT aborts a write
    host_load(6'd9, 8'h42);
    do_access(1'b0, 6'd9, 8'h00, 8'h42);
    @(negedge clk);
    req = 1'b1; iwr = 1'b1; addr = 6'd9; din = 8'hFF;
    @(posedge clk); #1;
    req = 1'b0;
    chk("wait_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_dout", int'(dout), 0);
    chk("abort_to_MAR", int'(to_MAR), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ack", int'(ack), 0);
    @(negedge clk) rst = 1'b0;
    do_access(1'b0, 6'd9, 8'h00, 8'h42);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
